// File: rtl/unsigned_div_pkg.sv
// Shared types and defaults for the sequential unsigned divider.
// Used by unsigned_div_step and unsigned_div_seq.
package unsigned_div_pkg;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Width of an iteration counter that must reach iterations-1.
    function automatic int cnt_width(input int iterations);
        return (iterations > 1) ? $clog2(iterations) : 1;
    endfunction

endpackage

// File: rtl/unsigned_div_step.sv
// One radix-2 restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference or restore, emit one quotient bit.
module unsigned_div_step
    import unsigned_div_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   i_prem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W:0]   o_prem,
    output logic                 o_qbit
);

    logic [DIVISOR_W+1:0] w_shifted;
    logic [DIVISOR_W:0]   w_diff;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        w_shifted = {i_prem, i_bit};
        o_qbit    = (w_shifted >= (DIVISOR_W+2)'(i_divisor));
        // Low bits of the modular difference are exact whenever the trial succeeds.
        w_diff    = w_shifted[DIVISOR_W:0] - (DIVISOR_W+1)'(i_divisor);
        o_prem    = o_qbit ? w_diff : w_shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/unsigned_div_seq.sv
// Sequential unsigned divider, one quotient bit per cycle, MSB first, ready/valid handshake.
// Optional macro UNSIGNED_DIV_ZERO_FLAG_EN: fast zero-divisor path with o_div_by_zero flag.
module unsigned_div_seq
    import unsigned_div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_ready,
    output logic                  o_valid,
    input  logic                  i_out_ready,
    output logic [DIVIDEND_W-1:0] o_quot,
    output logic [DIVISOR_W-1:0]  o_rem,
    output logic                  o_div_by_zero
);

`ifdef UNSIGNED_DIV_ZERO_FLAG_EN
    localparam bit ZERO_FLAG_EN = 1'b1;
`else
    localparam bit ZERO_FLAG_EN = 1'b0;
`endif

    localparam int                CNT_W     = cnt_width(DIVIDEND_W);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DIVIDEND_W - 1);

    div_state_t            r_state;
    logic [CNT_W-1:0]      r_count;
    logic [DIVISOR_W:0]    r_prem;
    logic [DIVIDEND_W-1:0] r_dq;       // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [DIVISOR_W-1:0]  r_divisor;
    logic                  r_zero;
    logic                  r_ready;
    logic                  r_valid;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_dbz;

    logic [DIVISOR_W:0]    w_prem_next;
    logic                  w_qbit;
    logic [DIVIDEND_W-1:0] w_dq_next;

    unsigned_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_prem    (r_prem),
        .i_bit     (r_dq[DIVIDEND_W-1]),
        .i_divisor (r_divisor),
        .o_prem    (w_prem_next),
        .o_qbit    (w_qbit)
    );

    assign w_dq_next = {r_dq[DIVIDEND_W-2:0], w_qbit};

    // NOTE: non-blocking assignments so every register in this block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_count   <= '0;
            r_prem    <= '0;
            r_dq      <= '0;
            r_divisor <= '0;
            r_zero    <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_state   <= BUSY;
                        r_ready   <= 1'b0;
                        r_prem    <= '0;
                        r_dq      <= i_dividend;
                        r_divisor <= i_divisor;
                        r_zero    <= ZERO_FLAG_EN && (i_divisor == '0);
                        // A flagged zero divisor spends a single cycle before DONE.
                        r_count   <= (ZERO_FLAG_EN && (i_divisor == '0)) ? LAST_ITER : '0;
                    end
                end
                BUSY: begin
                    r_prem  <= w_prem_next;
                    r_dq    <= w_dq_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_ITER) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        r_dbz   <= r_zero;
                        if (r_zero) begin
                            r_quot <= '1;
                            r_rem  <= r_dq[DIVISOR_W-1:0];
                        end else begin
                            r_quot <= w_dq_next;
                            r_rem  <= w_prem_next[DIVISOR_W-1:0];
                        end
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready       = r_ready;
    assign o_valid       = r_valid;
    assign o_quot        = r_quot;
    assign o_rem         = r_rem;
    assign o_div_by_zero = r_dbz;

    // Handshake invariants: never ready and valid together; results frozen while stalled.
    a_ready_valid_excl : assert property (@(posedge clk) disable iff (rst)
        !(r_ready && r_valid));

    a_hold_stalled : assert property (@(posedge clk) disable iff (rst)
        (r_valid && !i_out_ready) |=>
            (r_valid && $stable(r_quot) && $stable(r_rem) && $stable(r_dbz)));

endmodule

// File: tb/tb_unsigned_div_seq.sv
// Self-checking bench for unsigned_div_seq: directed table, stall/reset sequences,
// and randomized divisions against an arithmetic reference model.
module tb_unsigned_div_seq;

    localparam int DW = 8;
    localparam int VW = 4;

`ifdef UNSIGNED_DIV_ZERO_FLAG_EN
    localparam bit FLAG = 1'b1;
`else
    localparam bit FLAG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [DW-1:0] i_dividend;
    logic [VW-1:0] i_divisor;
    logic          o_ready;
    logic          o_valid;
    logic          i_out_ready;
    logic [DW-1:0] o_quot;
    logic [VW-1:0] o_rem;
    logic          o_div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unsigned_div_seq #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (VW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_ready       (o_ready),
        .o_valid       (o_valid),
        .i_out_ready   (i_out_ready),
        .o_quot        (o_quot),
        .o_rem         (o_rem),
        .o_div_by_zero (o_div_by_zero)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        int            stall;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor yields all-ones quotient and low dividend bits.
    function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                  output logic [DW-1:0] q, output logic [VW-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a[VW-1:0];
        end else begin
            q = a / {4'b0, b};
            r = VW'(a % {4'b0, b});
        end
    endfunction

    // Issue one request at a negedge with o_ready high; check latency, result, stall hold, release.
    task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input logic [DW-1:0] q, input logic [VW-1:0] r,
                           input int stall, input string tag);
        int   lat;
        int   exp_lat;
        logic ready_seen;
        logic exp_z;
        exp_z   = FLAG && (b == '0);
        exp_lat = exp_z ? 1 : DW;
        check({tag, " ready_before"}, 32'(o_ready), 32'd1);
        i_out_ready = (stall == 0);
        i_valid     = 1'b1;
        i_dividend  = a;
        i_divisor   = b;
        @(posedge clk);
        @(negedge clk);
        i_valid    = 1'b0;
        i_dividend = DW'($urandom);
        i_divisor  = VW'($urandom);
        lat        = 0;
        ready_seen = 1'b0;
        while (!o_valid && lat < 40) begin
            ready_seen = ready_seen | o_ready;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"},    32'(lat),           32'(exp_lat));
        check({tag, " ready_busy"}, 32'(ready_seen),    32'd0);
        check({tag, " valid"},      32'(o_valid),       32'd1);
        check({tag, " quot"},       32'(o_quot),        32'(q));
        check({tag, " rem"},        32'(o_rem),         32'(r));
        check({tag, " dbz"},        32'(o_div_by_zero), 32'(exp_z));
        for (int i = 0; i < stall; i++) begin
            i_valid    = 1'($urandom);
            i_dividend = DW'($urandom);
            i_divisor  = VW'($urandom);
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(o_valid),       32'd1);
            check({tag, " hold_ready"}, 32'(o_ready),       32'd0);
            check({tag, " hold_quot"},  32'(o_quot),        32'(q));
            check({tag, " hold_rem"},   32'(o_rem),         32'(r));
            check({tag, " hold_dbz"},   32'(o_div_by_zero), 32'(exp_z));
        end
        i_valid     = 1'b0;
        i_out_ready = 1'b1;
        @(negedge clk);
        check({tag, " ready_after"}, 32'(o_ready), 32'd1);
        check({tag, " valid_after"}, 32'(o_valid), 32'd0);
        check({tag, " quot_kept"},   32'(o_quot),  32'(q));
        check({tag, " rem_kept"},    32'(o_rem),   32'(r));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[6];
        logic          seen;
        logic [DW-1:0] a, q;
        logic [VW-1:0] b, r;
        int            stall;

        vecs[0] = '{a: 8'h05, b: 4'h2, q: 8'h02, r: 4'h1, stall: 0};
        vecs[1] = '{a: 8'h0C, b: 4'h4, q: 8'h03, r: 4'h0, stall: 0};
        vecs[2] = '{a: 8'hFF, b: 4'hF, q: 8'h11, r: 4'h0, stall: 0};
        vecs[3] = '{a: 8'h03, b: 4'h9, q: 8'h00, r: 4'h3, stall: 0};
        vecs[4] = '{a: 8'h37, b: 4'h0, q: 8'hFF, r: 4'h7, stall: 0};
        vecs[5] = '{a: 8'h9B, b: 4'h7, q: 8'h16, r: 4'h1, stall: 5};

        rst         = 1'b1;
        i_valid     = 1'b0;
        i_dividend  = '0;
        i_divisor   = '0;
        i_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset ready", 32'(o_ready),       32'd1);
        check("reset valid", 32'(o_valid),       32'd0);
        check("reset quot",  32'(o_quot),        32'd0);
        check("reset rem",   32'(o_rem),         32'd0);
        check("reset dbz",   32'(o_div_by_zero), 32'd0);

        // Back-to-back directed vectors, then a 5-cycle consumer stall with ignored i_valid pulses.
        for (int i = 0; i < 6; i++)
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].stall,
                    $sformatf("vec%0d", i));

        // Reset in the third BUSY cycle, with i_valid also high to test reset priority.
        i_valid    = 1'b1;
        i_dividend = 8'hC8;
        i_divisor  = 4'h3;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst     = 1'b1;
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        i_valid = 1'b0;
        check("abort ready", 32'(o_ready),       32'd1);
        check("abort valid", 32'(o_valid),       32'd0);
        check("abort quot",  32'(o_quot),        32'd0);
        check("abort rem",   32'(o_rem),         32'd0);
        check("abort dbz",   32'(o_div_by_zero), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | o_valid;
        end
        check("abort no_result", 32'(seen), 32'd0);

        for (int n = 0; n < 150; n++) begin
            a = DW'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 4'h0 : VW'($urandom_range(1, 15));
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            model(a, b, q, r);
            run_div(a, b, q, r, stall, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unsigned_div_seq.md
UNSIGNED_DIV_SEQ -- requirements
Module: unsigned_div_seq

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 8, dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_W, default 4, divisor and remainder width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  request valid.
REQ-006 SHALL have port i_dividend  input  DIVIDEND_W  unsigned dividend.
REQ-007 SHALL have port i_divisor  input  DIVISOR_W  unsigned divisor.
REQ-008 SHALL have port o_ready  output  1  block can accept a request.
REQ-009 SHALL have port o_valid  output  1  result valid.
REQ-010 SHALL have port i_out_ready  input  1  consumer takes result.
REQ-011 SHALL have port o_quot  output  DIVIDEND_W  quotient.
REQ-012 SHALL have port o_rem  output  DIVISOR_W  remainder.
REQ-013 SHALL have port o_div_by_zero  output  1  divisor was zero.

Function
REQ-014 SHALL compute o_quot = floor(dividend/divisor), o_rem = dividend mod divisor, unsigned, by radix-2 restoring division, one quotient bit per cycle, MSB first.
REQ-015 SHALL keep a partial remainder of DIVISOR_W+1 bits internally; o_rem is its low DIVISOR_W bits.
REQ-016 SHALL implement FSM IDLE, BUSY, DONE: IDLE->BUSY on i_valid&&o_ready; BUSY->DONE after DIVIDEND_W iterations; DONE->IDLE on i_out_ready.
REQ-017 SHALL drive o_ready=1 only in IDLE; SHALL sample i_dividend/i_divisor only at the accepting edge; i_valid outside IDLE is ignored.
REQ-018 SHALL assert o_valid only in DONE, exactly DIVIDEND_W cycles after the accepting edge (normal path).
REQ-019 SHALL hold o_valid, o_quot, o_rem, o_div_by_zero stable while o_valid=1 and i_out_ready=0.
REQ-020 SHALL return to IDLE on the edge where o_valid&&i_out_ready; o_ready=1 the following cycle; no same-cycle DONE-to-accept.
REQ-021 SHALL, for divisor zero on the normal path, produce o_quot=all ones, o_rem=dividend[DIVISOR_W-1:0].
REQ-022 SHALL produce o_quot=0, o_rem=dividend when dividend<divisor.
REQ-023 SHALL keep o_quot/o_rem at the last result in IDLE and BUSY until overwritten at DONE entry.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, go to IDLE and clear o_valid, o_quot, o_rem, o_div_by_zero, iteration counter and partial remainder; o_ready=1 after the reset edge.
REQ-025 SHALL abort any in-flight division on reset; no result is delivered for it.
REQ-026 SHALL give rst priority over i_valid and i_out_ready in the same cycle.

Configuration
REQ-027 SHALL support macro UNSIGNED_DIV_ZERO_FLAG_EN.
REQ-028 With UNSIGNED_DIV_ZERO_FLAG_EN defined: a zero divisor at acceptance skips BUSY and enters DONE on the next edge (o_valid 1 cycle after acceptance) with o_quot=all ones, o_rem=dividend[DIVISOR_W-1:0], o_div_by_zero=1.
REQ-029 Without it: zero divisor takes the normal DIVIDEND_W-cycle path per REQ-021; o_div_by_zero tied 0.

Structure
REQ-030 SHALL place the FSM state typedef (IDLE, BUSY, DONE) and default width constants in package unsigned_div_pkg.
REQ-031 SHALL implement one iteration (shift-in, trial subtract, restore, quotient bit) as combinational sub-module unsigned_div_step, instantiated once.

Verification
REQ-032 Accept 0x05/0x2 -> o_valid 8 cycles later, o_quot=0x02, o_rem=0x1, o_div_by_zero=0.
REQ-033 Accept 0x0C/0x4, then 0xFF/0xF back-to-back with i_out_ready=1 -> 0x03 r0x0, then 0x11 r0x0; o_ready low during each BUSY.
REQ-034 Accept 0x03/0x9 -> o_quot=0x00, o_rem=0x3.
REQ-035 Accept 0x37/0x0 -> with macro: o_valid after 1 cycle, quot 0xFF, rem 0x7, flag 1; without: after 8 cycles, same data, flag 0.
REQ-036 Result with i_out_ready low 5 cycles -> o_valid and data unchanged, o_ready=0, i_valid pulses ignored; release -> o_ready=1 next cycle.
REQ-037 rst=1 at third BUSY cycle -> next cycle IDLE, o_ready=1, all outputs 0, no o_valid for the aborted request.
